// File: rtl/ring_pkg.sv
// Shared definitions for the ring router: header layout, direction encoding,
// ring distance and saturating-add helpers.
package ring_pkg;

    typedef enum logic [1:0] {
        DIR_CW  = 2'd0,
        DIR_CCW = 2'd1,
        DIR_PE  = 2'd2
    } ring_dir_e;

    // Destination field MSB sits this many bits below the flit width.
    localparam int DEST_MSB_OFS = 1;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Hops needed going clockwise from node to dest.
    function automatic int unsigned ring_dist(input int unsigned dest,
                                              input int unsigned node,
                                              input int unsigned n);
        return (dest + n - node) % n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/ring_rr_arb.sv
// N-requester round-robin arbiter; pointer moves past the winner only when
// the caller reports the grant was actually taken.
module ring_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N < 2) ? 1 : $clog2(N);
    localparam int IW = PW + 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [IW-1:0] idx_w;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = ptr_q;
        idx_w = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx_w = {1'b0, ptr_q} + IW'(i);
            if (idx_w >= IW'(N)) idx_w = idx_w - IW'(N);
            idx = idx_w[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                win      = idx;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ring_router_vc.sv
// Bidirectional ring router node with even/odd one-flit VC buffers per input.
// Optional statistics counters are built when RING_ROUTER_STATS_EN is defined.
module ring_router_vc
    import ring_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int NODE_ID   = 0,
    parameter int DATA_W    = 64,
    parameter int ID_W      = id_width(NUM_NODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              cwsi,
    input  logic              ccwsi,
    input  logic              pesi,
    output logic              cwri,
    output logic              ccwri,
    output logic              peri,
    input  logic [DATA_W-1:0] cwdi,
    input  logic [DATA_W-1:0] ccwdi,
    input  logic [DATA_W-1:0] pedi,
    output logic              cwso,
    output logic              ccwso,
    output logic              peso,
    input  logic              cwro,
    input  logic              ccwro,
    input  logic              pero,
    output logic [DATA_W-1:0] cwdo,
    output logic [DATA_W-1:0] ccwdo,
    output logic [DATA_W-1:0] pedo
`ifdef RING_ROUTER_STATS_EN
    ,
    output logic [31:0]       stat_fwd,
    output logic [31:0]       stat_inj,
    output logic [31:0]       stat_ej
`endif
);

    localparam int IN_CW   = 0;
    localparam int IN_CCW  = 1;
    localparam int IN_PE   = 2;
    localparam int DEST_HI = DATA_W - DEST_MSB_OFS;

    logic [DATA_W-1:0] buf_data_q [3][2];
    logic [DATA_W-1:0] buf_data_d [3][2];
    logic [1:0]        buf_vld_q  [3];
    logic [1:0]        buf_vld_d  [3];

    logic [2:0]        in_si, in_ri, off_vld, off_local, drain;
    logic [DATA_W-1:0] in_di    [3];
    logic [DATA_W-1:0] off_data [3];
    logic              off_idx;
    logic [ID_W-1:0]   pe_dest;
    ring_dir_e         pe_dir;

    logic [1:0] cw_req, cw_gnt, ccw_req, ccw_gnt;
    logic [2:0] pe_req, pe_gnt;
    logic       cw_xfer, ccw_xfer, pe_xfer;

    assign in_si    = {pesi, ccwsi, cwsi};
    assign in_di[0] = cwdi;
    assign in_di[1] = ccwdi;
    assign in_di[2] = pedi;
    assign off_idx  = ~polarity;

    // Capture side owns buf[polarity]; forward side only ever looks at buf[~polarity].
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_ri[i]     = ~buf_vld_q[i][polarity];
            off_data[i]  = buf_data_q[i][off_idx];
            off_vld[i]   = buf_vld_q[i][off_idx];
            off_local[i] = off_vld[i] && (off_data[i][DEST_HI -: ID_W] == ID_W'(NODE_ID));
        end
    end

    assign cwri  = in_ri[IN_CW];
    assign ccwri = in_ri[IN_CCW];
    assign peri  = in_ri[IN_PE];

    always_comb begin
        pe_dest = off_data[IN_PE][DEST_HI -: ID_W];
        if (off_local[IN_PE])
            pe_dir = DIR_PE;
        else if (ring_dist(32'(pe_dest), 32'(NODE_ID), 32'(NUM_NODES)) <= 32'(NUM_NODES / 2))
            pe_dir = DIR_CW;
        else
            pe_dir = DIR_CCW;
    end

    assign cw_req  = {off_vld[IN_PE] && (pe_dir == DIR_CW),  off_vld[IN_CW]  && !off_local[IN_CW]};
    assign ccw_req = {off_vld[IN_PE] && (pe_dir == DIR_CCW), off_vld[IN_CCW] && !off_local[IN_CCW]};
    assign pe_req  = off_local;

    ring_rr_arb #(.N(2)) u_arb_cw  (.clk(clk), .reset(reset), .req(cw_req),  .advance(cw_xfer),  .gnt(cw_gnt));
    ring_rr_arb #(.N(2)) u_arb_ccw (.clk(clk), .reset(reset), .req(ccw_req), .advance(ccw_xfer), .gnt(ccw_gnt));
    ring_rr_arb #(.N(3)) u_arb_pe  (.clk(clk), .reset(reset), .req(pe_req),  .advance(pe_xfer),  .gnt(pe_gnt));

    assign cwso  = |cw_gnt;
    assign ccwso = |ccw_gnt;
    assign peso  = |pe_gnt;
    assign cwdo  = ({DATA_W{cw_gnt[0]}} & off_data[IN_CW]) | ({DATA_W{cw_gnt[1]}} & off_data[IN_PE]);
    assign ccwdo = ({DATA_W{ccw_gnt[0]}} & off_data[IN_CCW]) | ({DATA_W{ccw_gnt[1]}} & off_data[IN_PE]);
    assign pedo  = ({DATA_W{pe_gnt[0]}} & off_data[IN_CW]) | ({DATA_W{pe_gnt[1]}} & off_data[IN_CCW])
                 | ({DATA_W{pe_gnt[2]}} & off_data[IN_PE]);

    assign cw_xfer  = cwso & cwro;
    assign ccw_xfer = ccwso & ccwro;
    assign pe_xfer  = peso & pero;

    assign drain[IN_CW]  = (cw_xfer & cw_gnt[0]) | (pe_xfer & pe_gnt[0]);
    assign drain[IN_CCW] = (ccw_xfer & ccw_gnt[0]) | (pe_xfer & pe_gnt[1]);
    assign drain[IN_PE]  = (cw_xfer & cw_gnt[1]) | (ccw_xfer & ccw_gnt[1]) | (pe_xfer & pe_gnt[2]);

    always_comb begin
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;
        for (int i = 0; i < 3; i++) begin
            if (drain[i]) buf_vld_d[i][off_idx] = 1'b0;
            if (in_si[i] && in_ri[i]) begin
                buf_vld_d[i][polarity]  = 1'b1;
                buf_data_d[i][polarity] = in_di[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) buf_vld_q <= '{default: '0};
        else       buf_vld_q <= buf_vld_d;
        buf_data_q <= buf_data_d;
    end

`ifdef RING_ROUTER_STATS_EN
    logic [31:0] stat_fwd_q, stat_fwd_d, stat_inj_q, stat_inj_d, stat_ej_q, stat_ej_d;
    logic [1:0]  fwd_inc;

    // Both ring outputs can pass a flit in the same cycle.
    always_comb begin
        fwd_inc    = 2'(cw_xfer & cw_gnt[0]) + 2'(ccw_xfer & ccw_gnt[0]);
        stat_fwd_d = sat_add(stat_fwd_q, 32'(fwd_inc));
        stat_inj_d = sat_add(stat_inj_q, 32'((cw_xfer & cw_gnt[1]) | (ccw_xfer & ccw_gnt[1])));
        stat_ej_d  = sat_add(stat_ej_q, 32'(pe_xfer));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fwd_q <= '0;
            stat_inj_q <= '0;
            stat_ej_q  <= '0;
        end else begin
            stat_fwd_q <= stat_fwd_d;
            stat_inj_q <= stat_inj_d;
            stat_ej_q  <= stat_ej_d;
        end
    end

    assign stat_fwd = stat_fwd_q;
    assign stat_inj = stat_inj_q;
    assign stat_ej  = stat_ej_q;
`endif

endmodule

// File: tb/tb_ring_router_vc.sv
// Directed bench for ring_router_vc at NUM_NODES=4, NODE_ID=1, DATA_W=16.
module tb_ring_router_vc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         polarity = 1'b0;
    logic         cwsi = 1'b0, ccwsi = 1'b0, pesi = 1'b0;
    logic         cwri, ccwri, peri;
    logic [W-1:0] cwdi = '0, ccwdi = '0, pedi = '0;
    logic         cwso, ccwso, peso;
    logic         cwro = 1'b1, ccwro = 1'b1, pero = 1'b1;
    logic [W-1:0] cwdo, ccwdo, pedo;
`ifdef RING_ROUTER_STATS_EN
    logic [31:0]  stat_fwd, stat_inj, stat_ej;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) polarity <= reset ? 1'b0 : ~polarity;

    ring_router_vc #(.NUM_NODES(4), .NODE_ID(1), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
        .cwri(cwri), .ccwri(ccwri), .peri(peri),
        .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
        .cwso(cwso), .ccwso(ccwso), .peso(peso),
        .cwro(cwro), .ccwro(ccwro), .pero(pero),
        .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
`ifdef RING_ROUTER_STATS_EN
        , .stat_fwd(stat_fwd), .stat_inj(stat_inj), .stat_ej(stat_ej)
`endif
    );

    task automatic test_reset();
        reset = 1'b1;
        cwsi = 1'b1; ccwsi = 1'b1; pesi = 1'b1;
        cwdi = 16'hC111; ccwdi = 16'h0222; pedi = 16'h4333;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
        checks++; if ({cwso, ccwso, peso} !== 3'b000) begin errors++; $display("FAIL reset_so: got %b want 000", {cwso, ccwso, peso}); end
        checks++; if (cwdo !== 16'h0) begin errors++; $display("FAIL reset_cwdo: got %h want 0000", cwdo); end
        checks++; if (ccwdo !== 16'h0) begin errors++; $display("FAIL reset_ccwdo: got %h want 0000", ccwdo); end
        checks++; if (pedo !== 16'h0) begin errors++; $display("FAIL reset_pedo: got %h want 0000", pedo); end
        checks++; if ({cwri, ccwri, peri} !== 3'b111) begin errors++; $display("FAIL reset_ri: got %b want 111", {cwri, ccwri, peri}); end
        repeat (2) begin
            @(negedge clk);
            checks++; if ({cwso, ccwso, peso} !== 3'b000) begin errors++; $display("FAIL reset_no_capture: got %b want 000", {cwso, ccwso, peso}); end
        end
    endtask

    task automatic test_inject(input logic [W-1:0] flit, input logic want_cw);
        @(negedge clk);
        pesi = 1'b1; pedi = flit;
        @(negedge clk);
        pesi = 1'b0;
        checks++;
        if ({cwso, ccwso, peso} !== {want_cw, ~want_cw, 1'b0}) begin
            errors++; $display("FAIL inject_dir %h: got %b want %b", flit, {cwso, ccwso, peso}, {want_cw, ~want_cw, 1'b0});
        end
        checks++;
        if ((want_cw ? cwdo : ccwdo) !== flit) begin
            errors++; $display("FAIL inject_data: got %h want %h", want_cw ? cwdo : ccwdo, flit);
        end
        @(negedge clk);
        checks++; if ({cwso, ccwso, peso} !== 3'b000) begin errors++; $display("FAIL inject_drain: got %b want 000", {cwso, ccwso, peso}); end
    endtask

    task automatic test_eject();
        @(negedge clk);
        cwsi = 1'b1; cwdi = 16'h4123;
        @(negedge clk);
        cwsi = 1'b0;
        checks++; if ({cwso, ccwso, peso} !== 3'b001) begin errors++; $display("FAIL eject_cw_so: got %b want 001", {cwso, ccwso, peso}); end
        checks++; if (pedo !== 16'h4123) begin errors++; $display("FAIL eject_cw_data: got %h want 4123", pedo); end
        @(negedge clk);
        ccwsi = 1'b1; ccwdi = 16'h4ABC;
        @(negedge clk);
        ccwsi = 1'b0;
        checks++; if ({cwso, ccwso, peso} !== 3'b001) begin errors++; $display("FAIL eject_ccw_so: got %b want 001", {cwso, ccwso, peso}); end
        checks++; if (pedo !== 16'h4ABC) begin errors++; $display("FAIL eject_ccw_data: got %h want 4abc", pedo); end
        @(negedge clk);
        pesi = 1'b1; pedi = 16'h4555;
        @(negedge clk);
        pesi = 1'b0;
        checks++; if ({cwso, ccwso, peso} !== 3'b001) begin errors++; $display("FAIL loopback_so: got %b want 001", {cwso, ccwso, peso}); end
        checks++; if (pedo !== 16'h4555) begin errors++; $display("FAIL loopback_data: got %h want 4555", pedo); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int       cw_sent = 0;
        int       pe_sent = 0;
        int       got = 0;
        int       cyc = 0;
        logic     stray = 1'b0;
        logic     bad;
        logic [9:0] seen_cw = '0;
        logic [9:0] seen_pe = '0;
        logic     from_cw [20];
        int       sq;
        while (got < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ccwso || peso) stray = 1'b1;
            if (cwso) begin
                sq  = int'(cwdo[3:0]);
                bad = (cwdo[13:4] !== 10'h0) || (sq > 9);
                if (!bad && cwdo[15:14] == 2'd3) begin
                    bad = seen_cw[sq];
                    seen_cw[sq] = 1'b1;
                    if (got < 20) from_cw[got] = 1'b1;
                end else if (!bad && cwdo[15:14] == 2'd2) begin
                    bad = seen_pe[sq];
                    seen_pe[sq] = 1'b1;
                    if (got < 20) from_cw[got] = 1'b0;
                end else begin
                    bad = 1'b1;
                end
                checks++; if (bad) begin errors++; $display("FAIL contention_flit: got %h want new dest2/dest3 flit", cwdo); end
                got++;
            end
            cwsi = (cw_sent < 10); cwdi = 16'hC000 | 16'(cw_sent);
            pesi = (pe_sent < 10); pedi = 16'h8000 | 16'(pe_sent);
            if (cwsi && cwri) cw_sent++;
            if (pesi && peri) pe_sent++;
        end
        cwsi = 1'b0; pesi = 1'b0;
        checks++; if (got != 20) begin errors++; $display("FAIL contention_count: got %0d want 20", got); end
        checks++; if ({seen_cw, seen_pe} !== 20'hFFFFF) begin errors++; $display("FAIL contention_lost: got %h want fffff", {seen_cw, seen_pe}); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL contention_stray: got %b want 0", stray); end
        for (int i = 0; i < 12 && i < got; i++) begin
            checks++;
            if (from_cw[i] !== (i % 2 == 0)) begin
                errors++; $display("FAIL contention_alternate[%0d]: got pass=%b want pass=%b", i, from_cw[i], (i % 2 == 0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        cwro = 1'b0; cwsi = 1'b1; cwdi = 16'hC0A1;
        @(negedge clk);
        cwdi = 16'hC0B2;
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0A1}) begin errors++; $display("FAIL bp_first: got %b/%h want 1/c0a1", cwso, cwdo); end
        @(negedge clk);
        cwsi = 1'b0;
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0B2}) begin errors++; $display("FAIL bp_second: got %b/%h want 1/c0b2", cwso, cwdo); end
        checks++; if (cwri !== 1'b0) begin errors++; $display("FAIL bp_full_ri_a: got %b want 0", cwri); end
        @(negedge clk);
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0A1}) begin errors++; $display("FAIL bp_hold_a: got %b/%h want 1/c0a1", cwso, cwdo); end
        checks++; if (cwri !== 1'b0) begin errors++; $display("FAIL bp_full_ri_b: got %b want 0", cwri); end
        @(negedge clk);
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0B2}) begin errors++; $display("FAIL bp_hold_b: got %b/%h want 1/c0b2", cwso, cwdo); end
        @(negedge clk);
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0A1}) begin errors++; $display("FAIL bp_release_a: got %b/%h want 1/c0a1", cwso, cwdo); end
        cwro = 1'b1;
        @(negedge clk);
        checks++; if ({cwso, cwdo} !== {1'b1, 16'hC0B2}) begin errors++; $display("FAIL bp_release_b: got %b/%h want 1/c0b2", cwso, cwdo); end
        checks++; if (cwri !== 1'b1) begin errors++; $display("FAIL bp_ri_freed: got %b want 1", cwri); end
        @(negedge clk);
        checks++; if (cwso !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", cwso); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cwro = 1'b0; ccwro = 1'b0; pero = 1'b0;
        cwsi = 1'b1; ccwsi = 1'b1; pesi = 1'b1;
        cwdi = 16'hC0C0; ccwdi = 16'h0D0D; pedi = 16'h4E0E;
        @(negedge clk);
        @(negedge clk);
        cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
        checks++; if ({cwri, ccwri, peri} !== 3'b000) begin errors++; $display("FAIL mid_full_ri: got %b want 000", {cwri, ccwri, peri}); end
        checks++; if ({cwso, ccwso, peso} !== 3'b111) begin errors++; $display("FAIL mid_full_so: got %b want 111", {cwso, ccwso, peso}); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({cwso, ccwso, peso} !== 3'b000) begin errors++; $display("FAIL mid_reset_so: got %b want 000", {cwso, ccwso, peso}); end
        checks++; if ({cwdo, ccwdo, pedo} !== 48'h0) begin errors++; $display("FAIL mid_reset_do: got %h want 0", {cwdo, ccwdo, pedo}); end
        checks++; if ({cwri, ccwri, peri} !== 3'b111) begin errors++; $display("FAIL mid_reset_ri: got %b want 111", {cwri, ccwri, peri}); end
`ifdef RING_ROUTER_STATS_EN
        checks++; if ({stat_fwd, stat_inj, stat_ej} !== 96'h0) begin errors++; $display("FAIL mid_reset_stats: got %0d/%0d/%0d want 0/0/0", stat_fwd, stat_inj, stat_ej); end
`endif
        reset = 1'b0; cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({cwso, ccwso, peso} !== 3'b000) begin errors++; $display("FAIL mid_reset_empty: got %b want 000", {cwso, ccwso, peso}); end
        end
    endtask

    initial begin
        test_reset();
        test_inject(16'h8ABC, 1'b1);
        test_inject(16'hC5A5, 1'b1);
        test_inject(16'h0F0F, 1'b0);
        test_eject();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
